// File: rtl/h264_pkg.sv
// Shared types and widths for the H.264 CAVLC back end.
package h264_pkg;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } packer_state_e;

   localparam int PACK_BUF_W   = 160;
   localparam int CAVLC_CODE_W = 128;
   localparam int CAVLC_LEN_W  = 7;
   localparam int WORD_W       = 32;
   localparam int COUNT_W      = 16;

endpackage

// File: rtl/bitstream_packer_if.sv
// Chunk-in / word-out handshake bundle between CAVLC, the packer and the writer.
interface bitstream_packer_if;
   import h264_pkg::*;

   logic                    cavlc_enc_valid;
   logic [CAVLC_CODE_W-1:0] cavlc_bitstream_code;
   logic [CAVLC_LEN_W-1:0]  cavlc_bitstream_bit;
   logic                    packer_ready;
   logic                    flush_i;
   logic                    word_valid;
   logic [WORD_W-1:0]       word_data;
   logic                    word_last;
   logic                    word_ready;
   logic                    flush_done;
   logic [COUNT_W-1:0]      word_count;

   modport master (
      output cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_i, word_ready,
      input  packer_ready, word_valid, word_data, word_last, flush_done, word_count
   );

   modport slave (
      input  cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_i, word_ready,
      output packer_ready, word_valid, word_data, word_last, flush_done, word_count
   );

endinterface

// File: rtl/bitstream_aligner.sv
// Places an LSB-aligned chunk directly below the bits already held in the packing buffer.
module bitstream_aligner
   import h264_pkg::*;
#(
   parameter int BUF_W  = PACK_BUF_W,
   parameter int FILL_W = $clog2(PACK_BUF_W + 1)
) (
   input  logic [CAVLC_CODE_W-1:0] code,
   input  logic [CAVLC_LEN_W-1:0]  len,
   input  logic [FILL_W-1:0]       fill_ap,
   output logic [BUF_W-1:0]        placed
);

   logic [BUF_W-1:0]  len_mask;
   logic [BUF_W-1:0]  code_ext;
   logic [FILL_W-1:0] shamt;

   // Bits above len-1 are masked so the zero-below-data invariant survives a dirty bus.
   always_comb begin
      len_mask = ~({BUF_W{1'b1}} << len);
      code_ext = BUF_W'(code) & len_mask;
      shamt    = FILL_W'(BUF_W) - fill_ap - FILL_W'(len);
      placed   = code_ext << shamt;
   end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length CAVLC chunks MSB-first into 32-bit words; flush adds RBSP trailing bits.
//
// state   | meaning
// S_RUN   | normal packing, chunks accepted while fill <= 32
// S_FLUSH | append stop bit, round fill up to a word boundary
// S_DRAIN | emit remaining words, last one flagged
// S_DONE  | one-cycle flush_done pulse
module bitstream_packer
   import h264_pkg::*;
#(
   parameter int BUF_W = PACK_BUF_W
) (
   input logic               clk,
   input logic               rst,
   bitstream_packer_if.slave bus
);

   localparam int                FILL_W = $clog2(BUF_W + 1);
   localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);

   packer_state_e      state;
   logic [BUF_W-1:0]   pack_buf;
   logic [FILL_W-1:0]  fill;
   logic               flush_pending;
   logic               flush_done_r;
   logic [COUNT_W-1:0] word_count_r;

   logic               word_valid;
   logic               pop;
   logic               ready;
   logic               accept;
   logic [FILL_W-1:0]  fill_ap;
   logic [BUF_W-1:0]   buf_ap;
   logic [BUF_W-1:0]   placed;
   logic [BUF_W-1:0]   stop_bit;
   logic [FILL_W-1:0]  fill_round;

   bitstream_aligner #(.BUF_W(BUF_W), .FILL_W(FILL_W)) u_aligner (
      .code    (bus.cavlc_bitstream_code),
      .len     (bus.cavlc_bitstream_bit),
      .fill_ap (fill_ap),
      .placed  (placed)
   );

   // Pop and push share a cycle, so every update works from the post-pop view.
   always_comb begin
      word_valid = (fill >= WORD_F);
      pop        = word_valid && bus.word_ready;
      fill_ap    = pop ? fill - WORD_F : fill;
      buf_ap     = pop ? pack_buf << WORD_W : pack_buf;
      ready      = (state == S_RUN) && (fill <= WORD_F) && !flush_pending;
      accept     = bus.cavlc_enc_valid && ready;
      stop_bit   = {{(BUF_W-1){1'b0}}, 1'b1} << (FILL_W'(BUF_W - 1) - fill_ap);
      fill_round = (fill_ap + WORD_F) & ~FILL_W'(WORD_W - 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_RUN;
         pack_buf      <= '0;
         fill          <= '0;
         flush_pending <= 1'b0;
         flush_done_r  <= 1'b0;
         word_count_r  <= '0;
      end else begin
         flush_done_r  <= 1'b0;
         flush_pending <= bus.flush_i || (flush_pending && (state != S_RUN));
         if (pop) word_count_r <= word_count_r + 1'b1;

         case (state)
            S_RUN: begin
               pack_buf <= accept ? (buf_ap | placed) : buf_ap;
               fill     <= accept ? fill_ap + FILL_W'(bus.cavlc_bitstream_bit) : fill_ap;
               if (flush_pending) state <= S_FLUSH;
            end
            S_FLUSH: begin
               pack_buf <= buf_ap | stop_bit;
               fill     <= fill_round;
               state    <= S_DRAIN;
            end
            S_DRAIN: begin
               pack_buf <= buf_ap;
               fill     <= fill_ap;
               if (fill_ap == '0) begin
                  state        <= S_DONE;
                  flush_done_r <= 1'b1;
               end
            end
            default: begin
               pack_buf <= buf_ap;
               fill     <= fill_ap;
               state    <= S_RUN;
            end
         endcase
      end
   end

   assign bus.packer_ready = ready;
   assign bus.word_valid   = word_valid;
   assign bus.word_data    = pack_buf[BUF_W-1 -: WORD_W];
   assign bus.word_last    = word_valid && (state == S_DRAIN) && (fill == WORD_F);
   assign bus.flush_done   = flush_done_r;
   assign bus.word_count   = word_count_r;

endmodule
